// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle RISC-V control unit with memory wait/timeout, trap state and retire counter.
// Optional feature macro: BRANCH_BNE_EN (adds BNE decode on opcode 1100011, funct3=001).
module mc_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             dMemAck,
  output logic [3:0]       ALUCtrl,
  output logic             ALUSrc,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             loadPC,
  output logic             PCSrc,
  output logic [2:0]       current_state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_IF = 3'b000, S_ID = 3'b001, S_EX = 3'b010,
    S_MEM = 3'b011, S_WB = 3'b100, S_TRAP = 3'b101
  } state_t;

  typedef enum logic [2:0] {
    C_LW = 3'd0, C_SW = 3'd1, C_R = 3'd2, C_I = 3'd3, C_BR = 3'd4
  } class_t;

  state_t            r_state, w_next;
  logic [31:0]       r_ir;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_retired;
  logic [1:0]        r_cause;
  logic [3:0]        r_alu_ctrl;
  logic              r_alu_src, r_mem_to_reg;

  class_t      w_class;
  logic        w_illegal, w_alu_src, w_bne;
  logic [3:0]  w_alu;
  logic [6:0]  w_opcode, w_funct7;
  logic [2:0]  w_funct3;
  logic        w_unused_ir;

  assign w_opcode    = r_ir[6:0];
  assign w_funct3    = r_ir[14:12];
  assign w_funct7    = r_ir[31:25];
  assign w_unused_ir = ^{r_ir[24:15], r_ir[11:7]};

  // Instruction decode from the latched IR: class, ALU op, immediate select, legality
  always_comb begin
    w_class   = C_R;
    w_illegal = 1'b0;
    w_alu     = 4'b0010;
    w_alu_src = 1'b0;
    w_bne     = 1'b0;
    case (w_opcode)
      7'b0000011: begin w_class = C_LW; w_alu_src = 1'b1; end
      7'b0100011: begin w_class = C_SW; w_alu_src = 1'b1; end
      7'b0110011: begin
        w_class = C_R;
        case ({w_funct7, w_funct3})
          {7'b0000000, 3'b000}: w_alu = 4'b0010;
          {7'b0100000, 3'b000}: w_alu = 4'b0110;
          {7'b0000000, 3'b111}: w_alu = 4'b0000;
          {7'b0000000, 3'b110}: w_alu = 4'b0001;
          {7'b0000000, 3'b001}: w_alu = 4'b1001;
          {7'b0000000, 3'b101}: w_alu = 4'b1000;
          {7'b0100000, 3'b101}: w_alu = 4'b1010;
          {7'b0000000, 3'b010}: w_alu = 4'b0100;
          {7'b0000000, 3'b100}: w_alu = 4'b0101;
          default:              w_illegal = 1'b1;
        endcase
      end
      7'b0010011: begin
        w_class   = C_I;
        w_alu_src = 1'b1;
        case (w_funct3)
          3'b000: w_alu = 4'b0010;
          3'b010: w_alu = 4'b0100;
          3'b100: w_alu = 4'b0101;
          3'b110: w_alu = 4'b0001;
          3'b111: w_alu = 4'b0000;
          3'b001: begin
            if (w_funct7 == 7'b0000000) w_alu = 4'b1001;
            else                        w_illegal = 1'b1;
          end
          3'b101: begin
            if (w_funct7 == 7'b0000000)      w_alu = 4'b1000;
            else if (w_funct7 == 7'b0100000) w_alu = 4'b1010;
            else                             w_illegal = 1'b1;
          end
          default: w_illegal = 1'b1;
        endcase
      end
      7'b1100011: begin
        w_class = C_BR;
        w_alu   = 4'b0110;
`ifdef BRANCH_BNE_EN
        case (w_funct3)
          3'b000:  w_bne = 1'b0;
          3'b001:  w_bne = 1'b1;
          default: w_illegal = 1'b1;
        endcase
`else
        w_bne = 1'b0;
`endif
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Next-state selection and Moore strobes
  always_comb begin
    w_next   = r_state;
    loadPC   = 1'b0;
    PCSrc    = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    case (r_state)
      S_IF: w_next = S_ID;
      S_ID: begin
        if (w_illegal) w_next = S_TRAP;
        else           w_next = S_EX;
      end
      S_EX: begin
        case (w_class)
          C_LW, C_SW: w_next = S_MEM;
          C_BR: begin
            w_next = S_IF;
            loadPC = 1'b1;
            PCSrc  = zero ^ w_bne;
          end
          default: w_next = S_WB;
        endcase
      end
      S_MEM: begin
        MemRead  = (w_class == C_LW);
        MemWrite = (w_class == C_SW);
        // Ack takes priority over an expiring wait counter
        if (dMemAck)                                       w_next = S_WB;
        else if ((MEM_TIMEOUT != 0) && (r_wait == TIMEOUT_V)) w_next = S_TRAP;
        else                                               w_next = S_MEM;
      end
      S_WB: begin
        w_next   = S_IF;
        loadPC   = 1'b1;
        RegWrite = (w_class != C_SW);
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_IF;
    endcase
  end

  // State, IR, wait/retire counters, trap cause and the EX-stable datapath controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IF;
      r_ir         <= 32'h0000_0000;
      r_wait       <= '0;
      r_retired    <= '0;
      r_cause      <= 2'b00;
      r_alu_ctrl   <= 4'b0000;
      r_alu_src    <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IF) r_ir <= instr;
      if (r_state != S_MEM)  r_wait <= '0;
      else if (!dMemAck)     r_wait <= r_wait + WAIT_W'(1);
      if ((r_state == S_WB) || ((r_state == S_EX) && (w_class == C_BR)))
        r_retired <= r_retired + CNT_W'(1);
      if ((w_next == S_TRAP) && (r_state != S_TRAP))
        r_cause <= (r_state == S_ID) ? 2'b01 : 2'b10;
      if ((r_state == S_ID) && (w_next == S_EX)) begin
        r_alu_ctrl   <= w_alu;
        r_alu_src    <= w_alu_src;
        r_mem_to_reg <= (w_class == C_LW);
      end else if ((w_next == S_IF) || (w_next == S_TRAP)) begin
        r_alu_ctrl   <= 4'b0000;
        r_alu_src    <= 1'b0;
        r_mem_to_reg <= 1'b0;
      end
    end
  end

  assign ALUCtrl       = r_alu_ctrl;
  assign ALUSrc        = r_alu_src;
  assign MemtoReg      = r_mem_to_reg;
  assign current_state = r_state;
  assign trap          = (r_state == S_TRAP);
  assign trap_cause    = r_cause;
  assign retired       = r_retired;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed self-checking bench for mc_ctrl_fsm (MEM_TIMEOUT=4); BNE checks under BRANCH_BNE_EN.
module tb_mc_ctrl_fsm;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n, zero, dMemAck;
  logic [31:0] instr;
  logic [3:0]  ALUCtrl;
  logic        ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, loadPC, PCSrc, trap;
  logic [2:0]  current_state;
  logic [1:0]  trap_cause;
  logic [31:0] retired;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ret = 0;

  mc_ctrl_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .dMemAck(dMemAck),
    .ALUCtrl(ALUCtrl), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .loadPC(loadPC), .PCSrc(PCSrc),
    .current_state(current_state), .trap(trap), .trap_cause(trap_cause), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] strobes();
    return 32'({loadPC, PCSrc, MemRead, MemWrite, RegWrite, ALUSrc, MemtoReg});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    check_eq("reset state", 32'(current_state), 32'd0);
    check_eq("reset retired", retired, 32'd0);
    check_eq("reset cause", 32'(trap_cause), 32'd0);
    rst_n   = 1'b1;
    exp_ret = 0;
  endtask

  // R/I instruction: IF, ID, EX, WB
  task automatic run_alu(input logic [31:0] ins, input logic [3:0] alu, input logic src);
    check_eq("alu IF state", 32'(current_state), 32'd0);
    instr = ins;
    tick();
    instr = 32'h0;
    check_eq("alu ID state", 32'(current_state), 32'd1);
    check_eq("alu ID ALUCtrl", 32'(ALUCtrl), 32'd0);
    tick();
    check_eq("alu EX state", 32'(current_state), 32'd2);
    check_eq("alu EX ALUCtrl", 32'(ALUCtrl), 32'(alu));
    check_eq("alu EX ALUSrc", 32'(ALUSrc), 32'(src));
    tick();
    check_eq("alu WB state", 32'(current_state), 32'd4);
    check_eq("alu WB strobes", strobes(), 32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, src, 1'b0}));
    check_eq("alu WB ALUCtrl", 32'(ALUCtrl), 32'(alu));
    tick();
    exp_ret++;
    check_eq("alu back IF", 32'(current_state), 32'd0);
    check_eq("alu retired", retired, 32'(exp_ret));
    check_eq("alu IF ALUCtrl", 32'(ALUCtrl), 32'd0);
  endtask

  // LW/SW: ack in MEM cycle waits+1, or never when waits < 0
  task automatic run_mem(input logic [31:0] ins, input logic ld, input int waits);
    int lim;
    lim = (waits >= 0) ? waits : TMO;
    check_eq("mem IF state", 32'(current_state), 32'd0);
    instr = ins;
    tick();
    instr = 32'h0;
    tick();
    check_eq("mem EX state", 32'(current_state), 32'd2);
    check_eq("mem EX strobes", strobes(), 32'({5'b00000, 1'b1, ld}));
    check_eq("mem EX ALUCtrl", 32'(ALUCtrl), 32'd2);
    tick();
    for (int i = 0; i <= lim; i++) begin
      check_eq("mem MEM state", 32'(current_state), 32'd3);
      check_eq("mem MEM strobes", strobes(), 32'({2'b00, ld, ~ld, 1'b0, 1'b1, ld}));
      if (i == waits) dMemAck = 1'b1;
      tick();
      dMemAck = 1'b0;
    end
    if (waits >= 0) begin
      check_eq("mem WB state", 32'(current_state), 32'd4);
      check_eq("mem WB strobes", strobes(), 32'({1'b1, 1'b0, 1'b0, 1'b0, ld, 1'b1, ld}));
      tick();
      exp_ret++;
      check_eq("mem back IF", 32'(current_state), 32'd0);
      check_eq("mem retired", retired, 32'(exp_ret));
    end else begin
      check_eq("tmo TRAP state", 32'(current_state), 32'd5);
      check_eq("tmo trap", 32'(trap), 32'd1);
      check_eq("tmo cause", 32'(trap_cause), 32'd2);
      check_eq("tmo strobes", strobes(), 32'd0);
      check_eq("tmo ALUCtrl", 32'(ALUCtrl), 32'd0);
      check_eq("tmo retired", retired, 32'(exp_ret));
      dMemAck = 1'b1;
      tick();
      tick();
      dMemAck = 1'b0;
      check_eq("tmo stays TRAP", 32'(current_state), 32'd5);
      check_eq("tmo strobes held", strobes(), 32'd0);
      check_eq("tmo cause held", 32'(trap_cause), 32'd2);
    end
  endtask

  task automatic run_br(input logic [31:0] ins, input logic z, input logic exp_pcsrc);
    check_eq("br IF state", 32'(current_state), 32'd0);
    instr = ins;
    tick();
    instr = 32'h0;
    tick();
    zero = z;
    #1;
    check_eq("br EX state", 32'(current_state), 32'd2);
    check_eq("br EX strobes", strobes(), 32'({1'b1, exp_pcsrc, 5'b00000}));
    check_eq("br EX ALUCtrl", 32'(ALUCtrl), 32'd6);
    tick();
    zero = 1'b0;
    exp_ret++;
    check_eq("br back IF", 32'(current_state), 32'd0);
    check_eq("br retired", retired, 32'(exp_ret));
  endtask

  task automatic run_ill(input logic [31:0] ins);
    instr = ins;
    tick();
    instr = 32'h0;
    tick();
    check_eq("ill TRAP state", 32'(current_state), 32'd5);
    check_eq("ill trap", 32'(trap), 32'd1);
    check_eq("ill cause", 32'(trap_cause), 32'd1);
    check_eq("ill strobes", strobes(), 32'd0);
    check_eq("ill retired", retired, 32'(exp_ret));
    tick();
    check_eq("ill stays TRAP", 32'(current_state), 32'd5);
    do_reset();
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
    return {f7, 5'd2, 5'd1, f3, 5'd3, op};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; instr = 32'h0; zero = 1'b0; dMemAck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst state", 32'(current_state), 32'd0);
    check_eq("rst strobes", strobes(), 32'd0);
    check_eq("rst ALUCtrl", 32'(ALUCtrl), 32'd0);
    check_eq("rst trap", 32'(trap), 32'd0);
    check_eq("rst cause", 32'(trap_cause), 32'd0);
    check_eq("rst retired", retired, 32'd0);
    rst_n = 1'b1;

    run_alu(32'h0050_0093, 4'b0010, 1'b1);
    run_mem(32'h0001_2083, 1'b1, 3);
    run_mem(32'h0011_2023, 1'b0, 0);
    run_mem(32'h0011_2023, 1'b0, TMO);
    run_mem(32'h0011_2023, 1'b0, -1);
    do_reset();

    run_br(32'h0020_8063, 1'b1, 1'b1);
    run_br(32'h0020_8063, 1'b0, 1'b0);
`ifdef BRANCH_BNE_EN
    run_br(32'h0020_9063, 1'b0, 1'b1);
    run_br(32'h0020_9063, 1'b1, 1'b0);
    run_ill(32'h0020_a063);
`else
    run_br(32'h0020_9063, 1'b0, 1'b0);
    run_br(32'h0020_a063, 1'b1, 1'b1);
`endif
    run_ill(32'h0000_007f);

    run_alu(mk(7'b0000000, 3'b000, 7'b0110011), 4'b0010, 1'b0);
    run_alu(mk(7'b0100000, 3'b000, 7'b0110011), 4'b0110, 1'b0);
    run_alu(mk(7'b0000000, 3'b111, 7'b0110011), 4'b0000, 1'b0);
    run_alu(mk(7'b0000000, 3'b110, 7'b0110011), 4'b0001, 1'b0);
    run_alu(mk(7'b0000000, 3'b001, 7'b0110011), 4'b1001, 1'b0);
    run_alu(mk(7'b0000000, 3'b101, 7'b0110011), 4'b1000, 1'b0);
    run_alu(mk(7'b0100000, 3'b101, 7'b0110011), 4'b1010, 1'b0);
    run_alu(mk(7'b0000000, 3'b010, 7'b0110011), 4'b0100, 1'b0);
    run_alu(mk(7'b0000000, 3'b100, 7'b0110011), 4'b0101, 1'b0);
    run_alu(mk(7'b0000000, 3'b001, 7'b0010011), 4'b1001, 1'b1);
    run_alu(mk(7'b0000000, 3'b101, 7'b0010011), 4'b1000, 1'b1);
    run_alu(mk(7'b0100000, 3'b101, 7'b0010011), 4'b1010, 1'b1);
    run_alu(mk(7'b0000101, 3'b111, 7'b0010011), 4'b0000, 1'b1);
    run_alu(mk(7'b1111111, 3'b010, 7'b0010011), 4'b0100, 1'b1);

    run_ill(mk(7'b0000000, 3'b011, 7'b0110011));
    run_ill(mk(7'b0100000, 3'b001, 7'b0110011));
    run_ill(mk(7'b0100000, 3'b001, 7'b0010011));
    run_ill(mk(7'b0000001, 3'b101, 7'b0010011));
    run_ill(mk(7'b0000000, 3'b000, 7'b0110111));

    run_alu(32'h0050_0093, 4'b0010, 1'b1);
    instr = 32'h0001_2083;
    tick();
    instr = 32'h0;
    tick();
    tick();
    check_eq("midrst MEM1 MemRead", 32'(MemRead), 32'd1);
    tick();
    check_eq("midrst MEM2 state", 32'(current_state), 32'd3);
    check_eq("midrst MEM2 MemRead", 32'(MemRead), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst MemRead drop", 32'(MemRead), 32'd0);
    check_eq("midrst strobes", strobes(), 32'd0);
    check_eq("midrst state", 32'(current_state), 32'd0);
    check_eq("midrst retired", retired, 32'd0);
    tick();
    rst_n = 1'b1;
    exp_ret = 0;
    run_alu(32'h0050_0093, 4'b0010, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
